// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
// Holds the state encoding, the address/byte widths, the position of the
// R/W bit inside the address byte, and a small address-compare helper.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;
    // R/W flag sits in the LSB of the first byte after START (1 = read)
    localparam int I2C_RW_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_REG      = 4'd3,
        ST_REG_ACK  = 4'd4,
        ST_DATA     = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_RD       = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_e;

    // True when the upper seven bits of a received first byte name this device
    function automatic logic i2c_addr_hit(input logic [I2C_BYTE_W-1:0] byte_in,
                                          input logic [I2C_ADDR_W-1:0] dev_addr);
        return (byte_in[I2C_BYTE_W-1:1] == dev_addr);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA line conditioning for the I2C target.
// Each raw pad line runs through SYNC_STAGES flops, then one more flop that
// serves as the edge detector. START/STOP are SDA edges seen while SCL was
// high on both the current and the previous synchronized sample.
// Flops reset to 1 so a released (idle) bus produces no spurious events.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Metastability chains for both pad inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
        end
    end

    // One-sample history of the synchronized lines for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign o_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target receiver: decodes START/STOP, matches a 7-bit device address,
// latches a register pointer and strobes one write per data byte with
// pointer auto-increment (wrapping 0xFF -> 0x00).
// Optional feature macro: I2C_TARGET_READ_EN adds the read path (RD/RD_ACK).
// Host write port: wr_valid is a one-cycle strobe with no back-pressure;
// wr_addr/wr_data are valid with it and hold until the next strobe.
// Every register update that touches the bus happens on synchronized SCL
// events, so sda_oe only ever moves while SCL is low and SCL is never held.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'h10,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  wr_valid,
    output logic [I2C_BYTE_W-1:0] wr_addr,
    output logic [I2C_BYTE_W-1:0] wr_data,
    output logic [I2C_BYTE_W-1:0] rd_addr,
    input  logic [I2C_BYTE_W-1:0] rd_data,
    output logic                  busy,
    output i2c_state_e            o_dbg_state
);

    i2c_state_e            r_state;
    i2c_state_e            w_next_state;
    logic                  w_sda;
    logic                  w_scl_rise;
    logic                  w_scl_fall;
    logic                  w_start;
    logic                  w_stop;
    logic [3:0]            r_bit_cnt;
    logic [3:0]            w_bit_cnt_n;
    logic [6:0]            r_shift;
    logic [6:0]            w_shift_n;
    logic [I2C_BYTE_W-1:0] r_ptr;
    logic [I2C_BYTE_W-1:0] w_ptr_n;
    logic [I2C_BYTE_W-1:0] r_wr_addr;
    logic [I2C_BYTE_W-1:0] w_wr_addr_n;
    logic [I2C_BYTE_W-1:0] r_wr_data;
    logic [I2C_BYTE_W-1:0] w_wr_data_n;
    logic                  r_sda_oe;
    logic                  w_sda_oe_n;
    logic                  r_busy;
    logic                  w_busy_n;
    logic                  r_wr_valid;
    logic                  w_wr_valid_n;
    logic [I2C_BYTE_W-1:0] w_byte_in;
    logic                  w_last_bit;
    logic                  w_addr_hit;
`ifdef I2C_TARGET_READ_EN
    logic                  r_rw;
    logic                  w_rw_n;
    logic                  r_rd_load;
    logic                  w_rd_load_n;
`else
    logic                  w_unused_rd;
    assign w_unused_rd = ^rd_data;
`endif

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // The byte as it stands once the bit sampled on this rise is shifted in
    assign w_byte_in  = {r_shift, w_sda};
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_addr_hit = i2c_addr_hit(w_byte_in, ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; START and STOP override every state
    always_comb begin
        w_next_state = r_state;
        if (w_start) begin
            w_next_state = ST_ADDR;
        end else if (w_stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise && w_last_bit) begin
                        if (w_addr_hit && !w_byte_in[I2C_RW_BIT]) begin
                            w_next_state = ST_ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
                        end else if (w_addr_hit) begin
                            w_next_state = ST_ADDR_ACK;
`endif
                        end else begin
                            w_next_state = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // Second fall in an ACK state closes the ACK bit slot
                    if (w_scl_fall && r_sda_oe) begin
`ifdef I2C_TARGET_READ_EN
                        w_next_state = r_rw ? ST_RD : ST_REG;
`else
                        w_next_state = ST_REG;
`endif
                    end
                end
                ST_REG: begin
                    if (w_scl_rise && w_last_bit) w_next_state = ST_REG_ACK;
                end
                ST_REG_ACK: begin
                    if (w_scl_fall && r_sda_oe) w_next_state = ST_DATA;
                end
                ST_DATA: begin
                    if (w_scl_rise && w_last_bit) w_next_state = ST_DATA_ACK;
                end
                ST_DATA_ACK: begin
                    if (w_scl_fall && r_sda_oe) w_next_state = ST_DATA;
                end
`ifdef I2C_TARGET_READ_EN
                ST_RD: begin
                    if (w_scl_fall && (r_bit_cnt == 4'd8)) w_next_state = ST_RD_ACK;
                end
                ST_RD_ACK: begin
                    // A released SDA on the controller's bit is a NACK
                    if (w_scl_rise && w_sda) begin
                        w_next_state = ST_IGNORE;
                    end else if (w_scl_fall) begin
                        w_next_state = ST_RD;
                    end
                end
`endif
                default: w_next_state = r_state;
            endcase
        end
    end

    // Output/datapath decode: next values of the shifter, pointer, strobe and SDA drive
    always_comb begin
        w_bit_cnt_n  = r_bit_cnt;
        w_shift_n    = r_shift;
        w_ptr_n      = r_ptr;
        w_wr_addr_n  = r_wr_addr;
        w_wr_data_n  = r_wr_data;
        w_sda_oe_n   = r_sda_oe;
        w_busy_n     = r_busy;
        w_wr_valid_n = 1'b0;
`ifdef I2C_TARGET_READ_EN
        w_rw_n       = r_rw;
        w_rd_load_n  = (w_next_state == ST_RD) && (r_state != ST_RD);
`endif
        if (w_start || w_stop) begin
            // Any partial byte is dropped; the pointer is kept
            w_bit_cnt_n = '0;
            w_sda_oe_n  = 1'b0;
            w_busy_n    = 1'b0;
        end else begin
            case (r_state)
                ST_ADDR, ST_REG, ST_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_n   = w_byte_in[6:0];
                        w_bit_cnt_n = r_bit_cnt + 4'd1;
                        if (w_last_bit) begin
                            w_bit_cnt_n = '0;
                            if (r_state == ST_ADDR) begin
`ifdef I2C_TARGET_READ_EN
                                w_rw_n = w_byte_in[I2C_RW_BIT];
`endif
                                if (w_next_state == ST_ADDR_ACK) w_busy_n = 1'b1;
                            end else if (r_state == ST_REG) begin
                                w_ptr_n = w_byte_in;
                            end else begin
                                w_wr_valid_n = 1'b1;
                                w_wr_addr_n  = r_ptr;
                                w_wr_data_n  = w_byte_in;
                                w_ptr_n      = r_ptr + 8'd1;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                    // First fall grabs SDA, the next fall lets it go
                    if (w_scl_fall) w_sda_oe_n = ~r_sda_oe;
                end
`ifdef I2C_TARGET_READ_EN
                ST_RD: begin
                    if (r_rd_load) begin
                        w_shift_n  = rd_data[6:0];
                        w_sda_oe_n = ~rd_data[7];
                    end else if (w_scl_rise) begin
                        w_bit_cnt_n = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_n  = 1'b0;
                            w_bit_cnt_n = '0;
                        end else begin
                            w_sda_oe_n = ~r_shift[6];
                            w_shift_n  = {r_shift[5:0], 1'b0};
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise && !w_sda) w_ptr_n = r_ptr + 8'd1;
                end
`endif
                default: begin
                    w_sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers; reset releases SDA immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_ptr      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_n;
            r_shift    <= w_shift_n;
            r_ptr      <= w_ptr_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_data  <= w_wr_data_n;
            r_sda_oe   <= w_sda_oe_n;
            r_busy     <= w_busy_n;
            r_wr_valid <= w_wr_valid_n;
        end
    end

`ifdef I2C_TARGET_READ_EN
    // Read-path control flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw      <= 1'b0;
            r_rd_load <= 1'b0;
        end else begin
            r_rw      <= w_rw_n;
            r_rd_load <= w_rd_load_n;
        end
    end
`endif

    assign sda_oe      = r_sda_oe;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign rd_addr     = r_ptr;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level I2C controller drives byte transfers,
// a transaction-level model predicts ACKs, writes and the pointer, and a
// per-cycle monitor matches every write strobe against the expected queue.
`timescale 1ns/1ps
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int         Q   = 10;   // clk cycles per quarter SCL period
    localparam logic [6:0] DEV = 7'h10;
`ifdef I2C_TARGET_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif
    localparam int PH_ADDR = 0;
    localparam int PH_REG  = 1;
    localparam int PH_DATA = 2;
    localparam int PH_READ = 3;
    localparam int PH_IDLE = 4;

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_valid;
    logic       busy;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    i2c_state_e dbg_state;
    logic [7:0] mem [256];

    int          n_checks;
    int          n_errors;
    logic [15:0] exp_q [$];
    logic [15:0] cap_q [$];
    bit          oe_forbidden;
    logic        prev_wv;

    int          m_phase;
    logic [7:0]  m_ptr;
    bit          m_busy;

    assign scl_in  = m_scl;
    assign sda_in  = m_sda & ~sda_oe;
    assign rd_data = mem[rd_addr];

    i2c_target #(
        .ADDR        (DEV),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish within 2 ms");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    task automatic model_start();
        m_phase = PH_ADDR;
        m_busy  = 1'b0;
    endtask

    task automatic model_stop();
        m_phase = PH_IDLE;
        m_busy  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ack);
        ack = 1'b0;
        case (m_phase)
            PH_ADDR: begin
                if (b[7:1] == DEV && (b[0] == 1'b0 || READ_EN)) begin
                    ack     = 1'b1;
                    m_busy  = 1'b1;
                    m_phase = b[0] ? PH_READ : PH_REG;
                end else begin
                    m_phase = PH_IDLE;
                end
            end
            PH_REG: begin
                m_ptr   = b;
                ack     = 1'b1;
                m_phase = PH_DATA;
            end
            PH_DATA: begin
                exp_q.push_back({m_ptr, b});
                m_ptr = m_ptr + 8'd1;
                ack   = 1'b1;
            end
            default: ack = 1'b0;
        endcase
    endtask

    task automatic model_read_ack(input bit acked);
        if (acked) m_ptr = m_ptr + 8'd1;
        else       m_phase = PH_IDLE;
    endtask

    // ---------------- bus driver tasks ----------------
    task automatic qwait();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        ack = ~sda_in;
        qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic read_byte(output logic [7:0] b, input bit do_ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; qwait();
            m_scl = 1'b1; qwait();
            b[i] = sda_in;
            qwait();
            m_scl = 1'b0; qwait();
        end
        m_sda = do_ack ? 1'b0 : 1'b1; qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic xfer_byte(input string nm, input logic [7:0] b);
        bit exp_ack;
        bit got_ack;
        model_byte(b, exp_ack);
        send_byte(b, got_ack);
        check(nm, got_ack, exp_ack);
    endtask

    // ---------------- scoreboard: per-cycle output monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                cap_q.push_back({wr_addr, wr_data});
                check("wr_single_cycle", prev_wv, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wr_strobe: unexpected write addr=0x%0h data=0x%0h, expected none",
                             wr_addr, wr_data);
                end else begin
                    check("wr_strobe", {wr_addr, wr_data}, exp_q.pop_front());
                end
            end
            if (oe_forbidden) check("sda_oe_quiet", sda_oe, 1'b0);
        end
        prev_wv <= wr_valid;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] rb;
        bit         seen;
        n_checks     = 0;
        n_errors     = 0;
        oe_forbidden = 1'b0;
        prev_wv      = 1'b0;
        m_scl        = 1'b1;
        m_sda        = 1'b1;
        m_ptr        = 8'h00;
        model_stop();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h33;
        mem[8'h40] = 8'h5A;
        mem[8'h41] = 8'hC3;

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        qwait();

        // Reset values
        check("rst_sda_oe",   sda_oe,    1'b0);
        check("rst_wr_valid", wr_valid,  1'b0);
        check("rst_wr_addr",  wr_addr,   8'h00);
        check("rst_wr_data",  wr_data,   8'h00);
        check("rst_rd_addr",  rd_addr,   8'h00);
        check("rst_busy",     busy,      1'b0);
        check("rst_state",    dbg_state, ST_IDLE);

        // Plain write: pointer 0x05, two data bytes
        model_start(); bus_start();
        xfer_byte("wr_ack_addr", 8'h20);
        xfer_byte("wr_ack_reg",  8'h05);
        xfer_byte("wr_ack_d0",   8'hA5);
        xfer_byte("wr_ack_d1",   8'h3C);
        check("wr_busy_mid", busy, m_busy);
        model_stop(); bus_stop(); qwait();
        check("wr_busy_after_stop", busy, m_busy);
        check("wr_ptr_model", rd_addr, m_ptr);
        check("wr_ptr_literal", rd_addr, 8'h07);
        check("wr_strobe_count", cap_q.size(), 2);
        check("wr_strobe0_literal", cap_q[0], 16'h05A5);
        check("wr_strobe1_literal", cap_q[1], 16'h063C);

        // Address mismatch: no ACK, no strobe, never busy
        oe_forbidden = 1'b1;
        model_start(); bus_start();
        xfer_byte("mm_nack_addr", 8'h22);
        xfer_byte("mm_nack_b1",   8'h05);
        xfer_byte("mm_nack_b2",   8'h11);
        check("mm_busy", busy, 1'b0);
        model_stop(); bus_stop(); qwait();
        oe_forbidden = 1'b0;
        check("mm_strobe_count", cap_q.size(), 2);
        check("mm_ptr_kept", rd_addr, 8'h07);

        // Pointer wrap 0xFF -> 0x00
        model_start(); bus_start();
        xfer_byte("wrap_ack_addr", 8'h20);
        xfer_byte("wrap_ack_reg",  8'hFF);
        xfer_byte("wrap_ack_d0",   8'h01);
        xfer_byte("wrap_ack_d1",   8'h02);
        model_stop(); bus_stop(); qwait();
        check("wrap_strobe_count", cap_q.size(), 4);
        check("wrap_strobe0_literal", cap_q[2], 16'hFF01);
        check("wrap_strobe1_literal", cap_q[3], 16'h0002);
        check("wrap_ptr_literal", rd_addr, 8'h01);

        // Aborted byte: 5 data bits then STOP, then a normal transfer
        model_start(); bus_start();
        xfer_byte("abort_ack_addr", 8'h20);
        xfer_byte("abort_ack_reg",  8'h10);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        model_stop(); bus_stop(); qwait();
        check("abort_no_strobe", cap_q.size(), 4);
        check("abort_ptr", rd_addr, 8'h10);
        model_start(); bus_start();
        xfer_byte("after_abort_ack_addr", 8'h20);
        xfer_byte("after_abort_ack_reg",  8'h07);
        xfer_byte("after_abort_ack_d0",   8'h99);
        model_stop(); bus_stop(); qwait();
        check("after_abort_strobe_literal", cap_q[4], 16'h0799);
        check("after_abort_ptr", rd_addr, m_ptr);

        // Read with repeated START
        model_start(); bus_start();
        xfer_byte("rd_ack_addr_w", 8'h20);
        xfer_byte("rd_ack_reg",    8'h40);
        model_start(); bus_start();
        xfer_byte("rd_ack_addr_r", 8'h21);
`ifdef I2C_TARGET_READ_EN
        check("rd_busy", busy, m_busy);
        read_byte(rb, 1'b1);
        check("rd_byte0_model", rb, mem[m_ptr]);
        check("rd_byte0_literal", rb, 8'h5A);
        model_read_ack(1'b1);
        read_byte(rb, 1'b0);
        check("rd_byte1_model", rb, mem[m_ptr]);
        check("rd_byte1_literal", rb, 8'hC3);
        model_read_ack(1'b0);
        model_stop(); bus_stop(); qwait();
        check("rd_ptr_literal", rd_addr, 8'h41);
`else
        model_stop(); bus_stop(); qwait();
        check("rd_ptr_literal", rd_addr, 8'h40);
`endif
        check("rd_ptr_model", rd_addr, m_ptr);
        check("rd_no_strobe", cap_q.size(), 5);

        // Asynchronous reset during the address ACK slot
        model_start(); bus_start();
        for (int i = 7; i >= 0; i--) send_bit(8'h20 >> i);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (sda_oe) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL ack_wait: sda_oe=0 after 100 clk, expected 1");
        end
        check("arst_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sda_oe",   sda_oe,   1'b0);
        check("arst_wr_valid", wr_valid, 1'b0);
        check("arst_wr_addr",  wr_addr,  8'h00);
        check("arst_wr_data",  wr_data,  8'h00);
        check("arst_rd_addr",  rd_addr,  8'h00);
        check("arst_busy",     busy,     1'b0);
        m_ptr = 8'h00;
        model_stop();
        m_scl = 1'b0; qwait();
        m_sda = 1'b1; m_scl = 1'b1; qwait();
        rst_n = 1'b1; qwait();
        check("arst_state", dbg_state, ST_IDLE);

        // Transfer after reset behaves normally
        model_start(); bus_start();
        xfer_byte("post_rst_ack_addr", 8'h20);
        xfer_byte("post_rst_ack_reg",  8'h00);
        xfer_byte("post_rst_ack_d0",   8'h11);
        model_stop(); bus_stop(); qwait();
        check("post_rst_ptr", rd_addr, 8'h01);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) receiver: the responding end of the bus our codec-init master drives. It decodes START/STOP, matches a 7-bit device address, ACKs, latches a register pointer and emits one write strobe per received data byte into a host-side register file, with auto-increment. It sits between the open-drain SCL/SDA pad buffers and a byte-wide register bank. Uses:
- a bench-side model of the AK4619 for closed-loop init tests;
- a board-side config port for an external controller.

## Interface
- `ADDR`, 7'h10, 7-bit device address matched against the first byte.
- `SYNC_STAGES`, 2, synchronizer depth on `scl_in`/`sda_in` (≥2).
- `clk`  in  1  system clock; must be ≥10× the SCL frequency.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `scl_in`  in  1  raw SCL from pad.
- `sda_in`  in  1  raw SDA from pad.
- `sda_oe`  out  1  1 = pull SDA low. The pad ties the output data to 0; this block never drives high.
- `wr_valid`  out  1  one-cycle write strobe.
- `wr_addr`  out  8  register address for `wr_valid`.
- `wr_data`  out  8  data byte for `wr_valid`.
- `rd_addr`  out  8  current pointer, used for reads (`I2C_TARGET_READ_EN`).
- `rd_data`  in  8  register contents at `rd_addr`; combinational or registered.
- `busy`  out  1  high from an address-match ACK until the next STOP or START.

## Operation
- **Line conditioning.** `scl_in`/`sda_in` pass through `SYNC_STAGES` flops, then a one-flop edge detector. Event definitions:
  - `scl_rise` / `scl_fall`: edges of synchronized SCL.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit timing.**
  - SDA is sampled on `scl_rise`.
  - `sda_oe` changes only on `scl_fall`.
- **State machine.** States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, RD, RD_ACK, IGNORE.
  - START from any state → ADDR, with the bit counter cleared.
  - STOP from any state → IDLE; `sda_oe` released, `busy` cleared.
  - ADDR: shift 8 bits, MSB first.
    - On match with R/W=0 → ADDR_ACK, `sda_oe` held for one bit slot.
    - On mismatch → IGNORE with no ACK.
  - ADDR_ACK → REG: the byte is stored to the pointer → REG_ACK (ACK).
  - REG_ACK → DATA. Each complete byte:
    - pulses `wr_valid` with `wr_addr` = pointer;
    - ACKs;
    - increments the pointer mod 256 (0xFF wraps to 0x00).
  - Repeated START mid-transfer re-enters ADDR. The pointer is retained.
  - A partial byte (fewer than 8 bits before START/STOP) is discarded, with no strobe.
  - IGNORE: `sda_oe`=0 until START/STOP.
- The pointer resets to 0 and is not cleared by STOP.
- `rd_addr` always equals the pointer.

## Timing
- **Reset values:** `sda_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, state IDLE.
- **Event latency:** an SCL/SDA pad edge becomes an internal event `SYNC_STAGES`+1 clk later.
- **Write strobe:** `wr_valid` asserts exactly 1 clk after the `scl_rise` event of the 8th data bit. `wr_addr`/`wr_data` are valid in the same cycle and hold until the next strobe.
- **ACK slot:** `sda_oe` asserts 1 clk after the `scl_fall` event ending bit 8. It deasserts 1 clk after the following `scl_fall` event.
- **Reset mid-transfer:** `sda_oe` is released immediately, since reset is asynchronous.
- **Bus hold:** the block never stretches SCL.

## Configuration
- `I2C_TARGET_READ_EN` defined:
  - Address with R/W=1 and a match → ACK → RD.
  - `rd_data` is latched 1 clk after the `scl_fall` that ends the ACK slot, and shifted out MSB first. Each bit is a '0' pulled via `sda_oe` or a released '1'.
  - After 8 bits the line is released (RD_ACK) and the controller's bit is sampled on `scl_rise`:
    - ACK → pointer+1, next byte;
    - NACK → IGNORE.
- Undefined: R/W=1 → no ACK, IGNORE. RD/RD_ACK are not synthesized, and `rd_data` is unused.

## Structure
- Package `i2c_pkg`:
  - state enum;
  - `I2C_ADDR_W`=7 and `I2C_BYTE_W`=8;
  - the R/W bit position constant.
- Sub-module `i2c_line_sync`: synchronizer plus edge/START/STOP detection, parameterized by `SYNC_STAGES`.

## Test plan
- **Write:** START, 0x20 (0x10,W), 0x05, 0xA5, 0x3C, STOP →
  - ACK on all four bytes;
  - `wr_valid` pulses twice: (0x05,0xA5), (0x06,0x3C);
  - `busy` low after STOP.
- **Address mismatch:** START, 0x22, 0x05, 0x11, STOP → `sda_oe` never asserted, no `wr_valid`, `busy` stays 0.
- **Pointer wrap:** pointer 0xFF, data 0x01, 0x02 → writes at 0xFF then 0x00.
- **Aborted byte:** START, 0x20, 0x10, 5 bits then STOP → the 0x10 pointer is ACKed, no strobe for the partial byte. The next transfer behaves normally.
- **Read, repeated START:** START, 0x20, 0x40, rSTART, 0x21, read 2 bytes ACK/NACK, `rd_data`=0x5A then 0xC3 →
  - with macro: bus shows 0x5A, 0xC3, and `rd_addr` ends at 0x41;
  - without macro: 0x21 is NACKed.
- **Async reset mid-ACK:** assert `rst_n`=0 while `sda_oe`=1 → `sda_oe`=0 within the same cycle, all outputs at reset values.
